edm_spi_cmd_decoder: RTL and testbench

- Sits between the SPI byte receiver and the discharge pulse generator inside fpga_slave.
- Consumes received SPI bytes and parses 3-byte parameter-write frames and 1-byte control commands.
- Holds the active discharge parameters (Ton, Toff, waveform, Ip) and drives start/stop strobes into the pulse generator.
- Parameters update atomically on frame completion.

---
 rtl/edm_pkg.sv | 33 +++
 rtl/edm_frame_timeout.sv | 29 ++
 rtl/edm_spi_cmd_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_edm_spi_cmd_decoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/edm_pkg.sv
// Shared constants, waveform codes and FSM state type for the EDM SPI command decoder.
// Readback command prefix exists only when EDM_CMD_READBACK_EN is defined.
package edm_pkg;

  localparam logic [6:0] ADDR_TON  = 7'h11;
  localparam logic [6:0] ADDR_TOFF = 7'h1E;
  localparam logic [6:0] ADDR_WAVE = 7'h1C;
  localparam logic [6:0] ADDR_IP   = 7'h13;

  localparam logic [7:0] CMD_START = 8'h06;
  localparam logic [7:0] CMD_STOP  = 8'h07;
`ifdef EDM_CMD_READBACK_EN
  localparam logic [5:0] CMD_RB_PREFIX = 6'b010000;  // 0x40..0x43
`endif

  localparam logic [15:0] WAVE_RES_CO = 16'h8000;
  localparam logic [15:0] WAVE_ISO_1  = 16'h2001;
  localparam logic [15:0] WAVE_ISO_2  = 16'h2002;
  localparam logic [15:0] WAVE_MIX_1  = 16'h6001;
  localparam logic [15:0] WAVE_PULSE  = 16'h4001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA_LO = 2'd1,
    DATA_HI = 2'd2
  } edm_state_e;

  function automatic logic wave_valid(input logic [15:0] v);
    return (v == WAVE_RES_CO) || (v == WAVE_ISO_1) || (v == WAVE_ISO_2) ||
           (v == WAVE_MIX_1)  || (v == WAVE_PULSE);
  endfunction

endpackage

// File: rtl/edm_frame_timeout.sv
// Inter-byte timeout counter: cleared by i_restart, counts while i_enable,
// o_expire_c asserts combinationally on the last allowed cycle.
module edm_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk_in,
  input  logic sys_rst,
  input  logic i_restart,
  input  logic i_enable,
  output logic o_expire_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_cnt <= '0;
    end else if (i_restart) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire_c = i_enable && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/edm_spi_cmd_decoder.sv
// Parses SPI bytes into 3-byte parameter writes and 1-byte control commands.
// Optional register readback over tx_byte/tx_load under EDM_CMD_READBACK_EN.
module edm_spi_cmd_decoder
  import edm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter logic [15:0] DEF_TON        = 16'd100,
  parameter logic [15:0] DEF_TOFF       = 16'd50,
  parameter logic [15:0] DEF_WAVE       = 16'h8000,
  parameter logic [15:0] DEF_IP         = 16'd0
) (
  input  logic        clk_in,
  input  logic        sys_rst,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  input  logic        cs_n_sync,
  output logic [15:0] ton_us,
  output logic [15:0] toff_us,
  output logic [15:0] waveform,
  output logic [15:0] ip_half_amp,
  output logic        param_update,
  output logic        machine_start,
  output logic        machine_stop,
  output logic        cmd_err,
`ifdef EDM_CMD_READBACK_EN
  output logic [7:0]  tx_byte,
  output logic        tx_load,
`endif
  output logic        frame_busy
);

  edm_state_e  r_state, w_state_nxt, w_cur;
  logic [6:0]  r_addr, w_addr_nxt;
  logic [7:0]  r_lo, w_lo_nxt;
  logic [15:0] r_ton, r_toff, r_wave, r_ip;
  logic [15:0] w_ton_nxt, w_toff_nxt, w_wave_nxt, w_ip_nxt, w_val;
  logic        r_upd, r_start, r_stop, r_err, r_busy;
  logic        w_upd_nxt, w_start_nxt, w_stop_nxt, w_err_nxt;
  logic        w_expire_c;
  logic        w_unused;
`ifdef EDM_CMD_READBACK_EN
  logic [7:0]  r_tx, w_tx_nxt, r_rb_hi, w_rb_hi_nxt;
  logic        r_load, w_load_nxt, r_rb_pend, w_pend_nxt;
  logic [15:0] w_sel;
`endif

  // Chip-select edges carry no framing meaning here.
  assign w_unused = cs_n_sync;

  edm_frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk_in     (clk_in),
    .sys_rst    (sys_rst),
    .i_restart  (rx_valid | ~r_busy | w_expire_c),
    .i_enable   (r_busy),
    .o_expire_c (w_expire_c)
  );

  always_ff @(posedge clk_in) begin
    if (sys_rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_lo    <= '0;
      r_ton   <= DEF_TON;
      r_toff  <= DEF_TOFF;
      r_wave  <= DEF_WAVE;
      r_ip    <= DEF_IP;
      r_upd   <= 1'b0;
      r_start <= 1'b0;
      r_stop  <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
`ifdef EDM_CMD_READBACK_EN
      r_tx      <= '0;
      r_rb_hi   <= '0;
      r_load    <= 1'b0;
      r_rb_pend <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_lo    <= w_lo_nxt;
      r_ton   <= w_ton_nxt;
      r_toff  <= w_toff_nxt;
      r_wave  <= w_wave_nxt;
      r_ip    <= w_ip_nxt;
      r_upd   <= w_upd_nxt;
      r_start <= w_start_nxt;
      r_stop  <= w_stop_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= (w_state_nxt != IDLE);
`ifdef EDM_CMD_READBACK_EN
      r_tx      <= w_tx_nxt;
      r_rb_hi   <= w_rb_hi_nxt;
      r_load    <= w_load_nxt;
      r_rb_pend <= w_pend_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_lo_nxt    = r_lo;
    w_ton_nxt   = r_ton;
    w_toff_nxt  = r_toff;
    w_wave_nxt  = r_wave;
    w_ip_nxt    = r_ip;
    w_upd_nxt   = 1'b0;
    w_start_nxt = 1'b0;
    w_stop_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    w_val       = {rx_byte, r_lo};
    w_cur       = r_state;
`ifdef EDM_CMD_READBACK_EN
    w_tx_nxt    = r_tx;
    w_rb_hi_nxt = r_rb_hi;
    w_load_nxt  = 1'b0;
    w_pend_nxt  = r_rb_pend;
    w_sel       = '0;
`endif

    // A timeout abandons the frame; a byte in the same cycle is decoded from IDLE.
    if (w_expire_c) begin
      w_cur       = IDLE;
      w_state_nxt = IDLE;
      w_err_nxt   = 1'b1;
    end

    if (rx_valid) begin
      case (w_cur)
        IDLE: begin
`ifdef EDM_CMD_READBACK_EN
          if (r_rb_pend) begin
            w_tx_nxt   = r_rb_hi;
            w_load_nxt = 1'b1;
            w_pend_nxt = 1'b0;
          end else
`endif
          if (rx_byte[7]) begin
            w_addr_nxt  = rx_byte[6:0];
            w_state_nxt = DATA_LO;
          end
`ifdef EDM_CMD_READBACK_EN
          else if (rx_byte[7:2] == CMD_RB_PREFIX) begin
            case (rx_byte[1:0])
              2'd0:    w_sel = r_ton;
              2'd1:    w_sel = r_toff;
              2'd2:    w_sel = r_wave;
              default: w_sel = r_ip;
            endcase
            w_tx_nxt    = w_sel[7:0];
            w_rb_hi_nxt = w_sel[15:8];
            w_load_nxt  = 1'b1;
            w_pend_nxt  = 1'b1;
          end
`endif
          else if (rx_byte == CMD_START) w_start_nxt = 1'b1;
          else if (rx_byte == CMD_STOP)  w_stop_nxt  = 1'b1;
          else                           w_err_nxt   = 1'b1;
        end
        DATA_LO: begin
          w_lo_nxt    = rx_byte;
          w_state_nxt = DATA_HI;
        end
        DATA_HI: begin
          w_state_nxt = IDLE;
          case (r_addr)
            ADDR_TON: begin
              if (w_val != 16'd0) begin w_ton_nxt = w_val; w_upd_nxt = 1'b1; end
              else w_err_nxt = 1'b1;
            end
            ADDR_TOFF: begin
              if (w_val != 16'd0) begin w_toff_nxt = w_val; w_upd_nxt = 1'b1; end
              else w_err_nxt = 1'b1;
            end
            ADDR_WAVE: begin
              if (wave_valid(w_val)) begin w_wave_nxt = w_val; w_upd_nxt = 1'b1; end
              else w_err_nxt = 1'b1;
            end
            ADDR_IP: begin
              w_ip_nxt  = w_val;
              w_upd_nxt = 1'b1;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign ton_us        = r_ton;
  assign toff_us       = r_toff;
  assign waveform      = r_wave;
  assign ip_half_amp   = r_ip;
  assign param_update  = r_upd;
  assign machine_start = r_start;
  assign machine_stop  = r_stop;
  assign cmd_err       = r_err;
  assign frame_busy    = r_busy;
`ifdef EDM_CMD_READBACK_EN
  assign tx_byte       = r_tx;
  assign tx_load       = r_load;
`endif

endmodule

// File: tb/tb_edm_spi_cmd_decoder.sv
// Randomized + directed bench for edm_spi_cmd_decoder against a queue-based
// frame model evaluated every clock.
module tb_edm_spi_cmd_decoder;

  localparam int unsigned TO = 50000;

  logic        clk_in = 1'b0;
  logic        sys_rst, rx_valid, cs_n_sync;
  logic [7:0]  rx_byte;
  logic [15:0] ton_us, toff_us, waveform, ip_half_amp;
  logic        param_update, machine_start, machine_stop, cmd_err, frame_busy;
`ifdef EDM_CMD_READBACK_EN
  logic [7:0]  tx_byte;
  logic        tx_load;
`endif

  always #5 clk_in = ~clk_in;

  edm_spi_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in        (clk_in),
    .sys_rst       (sys_rst),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .cs_n_sync     (cs_n_sync),
    .ton_us        (ton_us),
    .toff_us       (toff_us),
    .waveform      (waveform),
    .ip_half_amp   (ip_half_amp),
    .param_update  (param_update),
    .machine_start (machine_start),
    .machine_stop  (machine_stop),
    .cmd_err       (cmd_err),
`ifdef EDM_CMD_READBACK_EN
    .tx_byte       (tx_byte),
    .tx_load       (tx_load),
`endif
    .frame_busy    (frame_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: parameters indexed 0=Ton 1=Toff 2=wave 3=Ip.
  logic [15:0] m_par [4];
  logic [7:0]  m_frm [$];
  int          m_gap;
  logic        m_upd, m_start, m_stop, m_err;
  logic        m_rb_pend, m_load;
  logic [7:0]  m_tx, m_rb_hi;

  function automatic int addr_idx(input logic [6:0] a);
    case (a)
      7'h11:   return 0;
      7'h1E:   return 1;
      7'h1C:   return 2;
      7'h13:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_commit(input logic [6:0] a, input logic [15:0] val);
    int k;
    k = addr_idx(a);
    if (k < 0) m_err = 1'b1;
    else if (k == 2 && !(val inside {16'h8000, 16'h2001, 16'h2002, 16'h6001, 16'h4001})) m_err = 1'b1;
    else if (k <= 1 && val == 16'd0) m_err = 1'b1;
    else begin m_par[k] = val; m_upd = 1'b1; end
  endtask

  task automatic model_step(input logic rst, input logic v, input logic [7:0] b);
    m_upd = 0; m_start = 0; m_stop = 0; m_err = 0; m_load = 0;
    if (rst) begin
      m_par[0] = 16'd100; m_par[1] = 16'd50; m_par[2] = 16'h8000; m_par[3] = 16'd0;
      m_frm.delete(); m_gap = 0; m_rb_pend = 0; m_tx = 8'h00; m_rb_hi = 8'h00;
      return;
    end
    if (m_frm.size() != 0) begin
      m_gap++;
      if (m_gap >= TO) begin m_frm.delete(); m_err = 1'b1; end
    end
    if (!v) return;
    m_gap = 0;
    if (m_frm.size() == 0) begin
`ifdef EDM_CMD_READBACK_EN
      if (m_rb_pend) begin m_tx = m_rb_hi; m_load = 1; m_rb_pend = 0; return; end
      if (b >= 8'h40 && b <= 8'h43) begin
        m_tx = m_par[b[1:0]][7:0]; m_rb_hi = m_par[b[1:0]][15:8];
        m_load = 1; m_rb_pend = 1; return;
      end
`endif
      if (b[7]) m_frm.push_back(b);
      else if (b == 8'h06) m_start = 1;
      else if (b == 8'h07) m_stop = 1;
      else m_err = 1;
    end else begin
      m_frm.push_back(b);
      if (m_frm.size() == 3) begin
        model_commit(m_frm[0][6:0], {m_frm[2], m_frm[1]});
        m_frm.delete();
      end
    end
  endtask

  // One clock: drive, let the edge happen, advance model, compare.
  task automatic cyc(input logic rst, input logic v, input logic [7:0] b);
    sys_rst = rst; rx_valid = v; rx_byte = b; cs_n_sync = 1'($urandom_range(0, 1));
    @(posedge clk_in);
    model_step(rst, v, b);
    #1;
    chk("ton", 32'(ton_us), 32'(m_par[0]));
    chk("toff", 32'(toff_us), 32'(m_par[1]));
    chk("wave", 32'(waveform), 32'(m_par[2]));
    chk("ip", 32'(ip_half_amp), 32'(m_par[3]));
    chk("upd", 32'(param_update), 32'(m_upd));
    chk("start", 32'(machine_start), 32'(m_start));
    chk("stop", 32'(machine_stop), 32'(m_stop));
    chk("err", 32'(cmd_err), 32'(m_err));
    chk("busy", 32'(frame_busy), 32'(m_frm.size() != 0));
    chk("start_stop_excl", 32'(machine_start & machine_stop), 32'd0);
`ifdef EDM_CMD_READBACK_EN
    chk("tx_load", 32'(tx_load), 32'(m_load));
    chk("tx_byte", 32'(tx_byte), 32'(m_tx));
`endif
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b0, 1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  initial begin
    int errs;
    logic [7:0] a;
    logic [15:0] val;
    sys_rst = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; cs_n_sync = 1'b1;
    repeat (3) cyc(1'b1, 1'b0, 8'h00);
    idle(1);
    chk("rst_ton", 32'(ton_us), 32'd100);
    chk("rst_toff", 32'(toff_us), 32'd50);
    chk("rst_wave", 32'(waveform), 32'h8000);
    chk("rst_ip", 32'(ip_half_amp), 32'd0);
    chk("rst_busy", 32'(frame_busy), 32'd0);

    send(8'h91); chk("t1_busy", 32'(frame_busy), 32'd1);
    send(8'h64); send(8'h00);
    chk("t1_upd", 32'(param_update), 32'd1);
    chk("t1_ton", 32'(ton_us), 32'd100);
    idle(1); chk("t1_upd_once", 32'(param_update), 32'd0);

    send(8'h9C); send(8'h01); send(8'h40);
    send(8'h93); send(8'h3C); send(8'h00);
    idle(1);
    chk("t2_wave", 32'(waveform), 32'h4001);
    chk("t2_ip", 32'(ip_half_amp), 32'd60);

    send(8'h9C); send(8'h34); send(8'h12);
    chk("t3_err", 32'(cmd_err), 32'd1);
    chk("t3_wave", 32'(waveform), 32'h4001);
    idle(1);

    send(8'h06); chk("t4_start", 32'(machine_start), 32'd1);
    idle(1);     chk("t4_start_off", 32'(machine_start), 32'd0);
    send(8'h07); chk("t4_stop", 32'(machine_stop), 32'd1);
    idle(1);     chk("t4_stop_off", 32'(machine_stop), 32'd0);

    send(8'h9E); send(8'h32);
    errs = 0;
    for (int i = 0; i < TO; i++) begin
      cyc(1'b0, 1'b0, 8'($urandom));
      errs += int'(cmd_err);
    end
    chk("t5_to_err", 32'(errs), 32'd1);
    chk("t5_toff", 32'(toff_us), 32'd50);
    send(8'h06); chk("t5_start", 32'(machine_start), 32'd1);

    send(8'h91); send(8'hC8); send(8'h00); idle(1);
    chk("t6_pre_ton", 32'(ton_us), 32'd200);
    send(8'h91); send(8'h64);
    cyc(1'b1, 1'b0, 8'h00);
    send(8'h00);
    chk("t6_err", 32'(cmd_err), 32'd1);
    chk("t6_ton", 32'(ton_us), 32'd100);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 2))
        0: begin
          case ($urandom_range(0, 3))
            0: a = 8'h91; 1: a = 8'h9E; 2: a = 8'h9C; default: a = 8'h93;
          endcase
          val = 16'($urandom);
          if ($urandom_range(0, 3) == 0) val = 16'd0;
          if (a == 8'h9C && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 4))
              0: val = 16'h8000; 1: val = 16'h2001; 2: val = 16'h2002;
              3: val = 16'h6001; default: val = 16'h4001;
            endcase
          end
          send(a); idle($urandom_range(0, 3));
          send(val[7:0]); idle($urandom_range(0, 3));
          send(val[15:8]);
        end
        1: begin
          send(8'h80 | 8'($urandom_range(0, 127)));
          idle($urandom_range(0, 2));
        end
        default: begin
          case ($urandom_range(0, 3))
            0: send(8'h06); 1: send(8'h07);
            2: send(8'h40 | 8'($urandom_range(0, 3)));
            default: send(8'($urandom_range(0, 127)));
          endcase
        end
      endcase
      idle($urandom_range(0, 3));
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
